// File: rtl/rule110_pkg.sv
// Shared types and constants for the Rule 110 array host-side sequencer.
package rule110_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DUMP_ADDR,
    S_DUMP_CAP,
    S_DUMP_OUT
  } seq_state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_RUN  = 2'b01;
  localparam logic [1:0] OP_DUMP = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  localparam int CELLS_PER_BLOCK = 8;

endpackage

// File: rtl/rule110_sequencer.sv
// Host-side LOAD/RUN/DUMP controller driving the Rule 110 cell array pins.
// Define RULE110_SEQ_AUTO_DUMP_EN to follow every nonzero RUN with an automatic full DUMP.
module rule110_sequencer
  import rule110_pkg::*;
#(
  parameter int NUM_BLOCKS = 30,
  parameter int ADDR_W     = 6,
  parameter int CNT_W      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [CNT_W-1:0]           cmd_count,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [CELLS_PER_BLOCK-1:0] wr_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [CELLS_PER_BLOCK-1:0] rd_data,
  output logic                       rd_last,
  output logic                       ca_we_n,
  output logic                       ca_halt_n,
  output logic [ADDR_W-1:0]          ca_addr,
  output logic [CELLS_PER_BLOCK-1:0] ca_data_in,
  input  logic [CELLS_PER_BLOCK-1:0] ca_data_out,
  output logic                       busy,
  output logic [CNT_W-1:0]           gen_count,
  output logic                       err
);

  // blk needs one extra bit so LOAD can count past the last block
  localparam int BLK_W = ADDR_W + 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(NUM_BLOCKS - 1);
  localparam logic [BLK_W-1:0] BLK_END  = BLK_W'(NUM_BLOCKS);

  seq_state_t                 state_q, state_d;
  logic [BLK_W-1:0]           blk_q, blk_d, blk_inc;
  logic [CNT_W-1:0]           rem_q, rem_d;
  logic                       cmd_ready_d, wr_ready_d, rd_valid_d, rd_last_d;
  logic                       ca_we_n_d, ca_halt_n_d, busy_d, err_d;
  logic [ADDR_W-1:0]          ca_addr_d;
  logic [CELLS_PER_BLOCK-1:0] ca_data_in_d, rd_data_d;
  logic [CNT_W-1:0]           gen_count_d;

  assign blk_inc = blk_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    blk_d        = blk_q;
    rem_d        = rem_q;
    wr_ready_d   = 1'b0;
    rd_valid_d   = rd_valid;
    rd_last_d    = rd_last;
    rd_data_d    = rd_data;
    ca_we_n_d    = 1'b1;
    ca_halt_n_d  = 1'b0;
    ca_addr_d    = ca_addr;
    ca_data_in_d = ca_data_in;
    err_d        = err;
    gen_count_d  = gen_count + {{(CNT_W-1){1'b0}}, ca_halt_n};

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          case (cmd_op)
            OP_LOAD: begin
              state_d    = S_LOAD;
              blk_d      = '0;
              wr_ready_d = 1'b1;
            end
            OP_RUN: begin
              state_d     = S_RUN;
              rem_d       = cmd_count;
              ca_halt_n_d = (cmd_count != '0);
            end
            OP_DUMP: begin
              state_d   = S_DUMP_ADDR;
              blk_d     = '0;
              ca_addr_d = '0;
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      // the write pulse lands the cycle after acceptance; LOAD ends one cycle after the last pulse
      S_LOAD: begin
        if (wr_valid && wr_ready) begin
          ca_we_n_d    = 1'b0;
          ca_addr_d    = blk_q[ADDR_W-1:0];
          ca_data_in_d = wr_data;
          blk_d        = blk_inc;
          wr_ready_d   = (blk_q != BLK_LAST);
        end else if (blk_q == BLK_END) begin
          state_d = S_IDLE;
        end else begin
          wr_ready_d = 1'b1;
        end
      end

      // rem counts halt-high cycles still owed, including the current one
      S_RUN: begin
        if (rem_q > CNT_W'(1)) begin
          rem_d       = rem_q - 1'b1;
          ca_halt_n_d = 1'b1;
        end else begin
`ifdef RULE110_SEQ_AUTO_DUMP_EN
          if (rem_q == CNT_W'(1)) begin
            state_d   = S_DUMP_ADDR;
            blk_d     = '0;
            ca_addr_d = '0;
          end else begin
            state_d = S_IDLE;
          end
`else
          state_d = S_IDLE;
`endif
        end
      end

      S_DUMP_ADDR: state_d = S_DUMP_CAP;

      S_DUMP_CAP: begin
        rd_data_d  = ca_data_out;
        rd_valid_d = 1'b1;
        rd_last_d  = (blk_q == BLK_LAST);
        state_d    = S_DUMP_OUT;
      end

      S_DUMP_OUT: begin
        if (rd_ready) begin
          rd_valid_d = 1'b0;
          rd_last_d  = 1'b0;
          if (blk_q == BLK_LAST) begin
            state_d = S_IDLE;
          end else begin
            blk_d     = blk_inc;
            ca_addr_d = blk_inc[ADDR_W-1:0];
            state_d   = S_DUMP_ADDR;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      blk_q      <= '0;
      rem_q      <= '0;
      cmd_ready  <= 1'b0;
      wr_ready   <= 1'b0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      ca_we_n    <= 1'b1;
      ca_halt_n  <= 1'b0;
      ca_addr    <= '0;
      ca_data_in <= '0;
      busy       <= 1'b0;
      gen_count  <= '0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      blk_q      <= blk_d;
      rem_q      <= rem_d;
      cmd_ready  <= cmd_ready_d;
      wr_ready   <= wr_ready_d;
      rd_valid   <= rd_valid_d;
      rd_last    <= rd_last_d;
      ca_we_n    <= ca_we_n_d;
      ca_halt_n  <= ca_halt_n_d;
      ca_addr    <= ca_addr_d;
      ca_data_in <= ca_data_in_d;
      busy       <= busy_d;
      gen_count  <= gen_count_d;
      err        <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    rd_data <= rd_data_d;
  end

endmodule

// File: tb/tb_rule110_sequencer.sv
// Bench for rule110_sequencer with an in-bench Rule 110 array and a generation-level reference.
module tb_rule110_sequencer;
  import rule110_pkg::*;

  localparam int NB = 4;
  localparam int AW = 6;
  localparam int CW = 16;
  localparam int NC = NB * 8;
  localparam logic [7:0] RULE_TAB = 8'b0110_1110;

  logic          clk, reset;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [CW-1:0] cmd_count;
  logic          wr_valid, wr_ready;
  logic [7:0]    wr_data;
  logic          rd_valid, rd_ready, rd_last;
  logic [7:0]    rd_data;
  logic          ca_we_n, ca_halt_n;
  logic [AW-1:0] ca_addr;
  logic [7:0]    ca_data_in, ca_data_out;
  logic          busy, err;
  logic [CW-1:0] gen_count;

  int checks = 0;
  int failures = 0;
  logic [NC-1:0] ref_state;
  logic [CW-1:0] exp_gen;

  rule110_sequencer #(.NUM_BLOCKS(NB), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_count(cmd_count),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .ca_we_n(ca_we_n), .ca_halt_n(ca_halt_n), .ca_addr(ca_addr),
    .ca_data_in(ca_data_in), .ca_data_out(ca_data_out),
    .busy(busy), .gen_count(gen_count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cell array stand-in: table-driven Rule 110, writes win over halt_n, reads show T+1
  logic [NC-1:0] arr, arr_nx;

  function automatic logic [NC-1:0] arr_next(input logic [NC-1:0] s);
    logic [NC-1:0] n;
    logic l, r;
    for (int i = 0; i < NC; i++) begin
      l = 1'b0;
      r = 1'b0;
      if (i > 0) l = s[i-1];
      if (i < NC - 1) r = s[i+1];
      n[i] = RULE_TAB[{l, s[i], r}];
    end
    return n;
  endfunction

  assign arr_nx = arr_next(arr);

  always_comb begin
    ca_data_out = 8'h00;
    if (ca_addr == '1) ca_data_out = arr_nx[7:0];
    else if (int'(ca_addr) < NB) ca_data_out = arr_nx[int'(ca_addr)*8 +: 8];
  end

  always @(posedge clk) begin : rule110_array_model
    if (!ca_we_n) begin
      if (int'(ca_addr) < NB) arr[int'(ca_addr)*8 +: 8] <= ca_data_in;
    end else if (ca_halt_n) begin
      arr <= arr_nx;
    end
  end

  // Reference: whole-row generations from the Boolean form of Rule 110
  function automatic logic [NC-1:0] ref_gen(input logic [NC-1:0] s, input int n);
    logic [NC-1:0] cur, nxt;
    logic l, c, r;
    cur = s;
    for (int g = 0; g < n; g++) begin
      for (int i = 0; i < NC; i++) begin
        l = (i == 0) ? 1'b0 : cur[(i == 0) ? 0 : i-1];
        r = (i == NC-1) ? 1'b0 : cur[(i == NC-1) ? i : i+1];
        c = cur[i];
        nxt[i] = (c | r) & ~(l & c & r);
      end
      cur = nxt;
    end
    return cur;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input logic [1:0] op, input logic [CW-1:0] cnt);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL cmd_ready_wait: got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_count = cnt;
    tick();
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_count = CW'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if ({cmd_ready, ca_we_n, ca_halt_n, ca_addr, ca_data_in, wr_ready, rd_valid, rd_last, busy, gen_count, err}
        !== {1'b0, 1'b1, 1'b0, AW'(0), 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, CW'(0), 1'b0}) begin
      failures++;
      $display("FAIL reset_values: rdy=%b we_n=%b halt_n=%b addr=%0d din=%h wr_rdy=%b rd_v=%b last=%b busy=%b gen=%0d err=%b",
               cmd_ready, ca_we_n, ca_halt_n, ca_addr, ca_data_in, wr_ready, rd_valid, rd_last, busy, gen_count, err);
    end
    reset = 1'b0;
    exp_gen = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if ({ca_halt_n, ca_we_n, cmd_ready, gen_count, err} !== {1'b0, 1'b1, 1'b1, CW'(0), 1'b0}) begin
        failures++;
        $display("FAIL idle_after_reset cycle %0d: halt_n=%b we_n=%b rdy=%b gen=%0d err=%b want 0 1 1 0 0",
                 c, ca_halt_n, ca_we_n, cmd_ready, gen_count, err);
      end
    end
  endtask

  task automatic test_load(input logic [NC-1:0] img, input bit b2b);
    int idx, np, first_p, last_p, idle_c;
    bit halt_seen, acc;
    idx = 0; np = 0; first_p = -1; last_p = -1; idle_c = -1; halt_seen = 0;
    issue_cmd(OP_LOAD, '0);
    for (int c = 0; c < 200; c++) begin
      if (!ca_we_n) begin
        checks++;
        if (np >= NB) begin
          failures++;
          $display("FAIL load_extra_pulse: pulse %0d addr=%0d want only %0d pulses", np, ca_addr, NB);
        end else if ({ca_addr, ca_data_in} !== {AW'(np), img[np*8 +: 8]}) begin
          failures++;
          $display("FAIL load_pulse %0d: addr=%0d data=%h want addr=%0d data=%h",
                   np, ca_addr, ca_data_in, np, img[np*8 +: 8]);
        end
        if (first_p < 0) first_p = c;
        last_p = c;
        np++;
      end
      if (ca_halt_n) halt_seen = 1;
      if (!busy) begin idle_c = c; break; end
      wr_valid = (idx < NB) && (b2b || $urandom_range(1, 0) == 1);
      wr_data  = (idx < NB) ? img[idx*8 +: 8] : 8'h00;
      acc = wr_valid && wr_ready;
      tick();
      if (acc) idx++;
    end
    wr_valid = 1'b0;
    checks++;
    if (np != NB || idle_c != last_p + 1 || halt_seen) begin
      failures++;
      $display("FAIL load_frame: pulses=%0d idle_cycle=%0d last_pulse=%0d halt_seen=%b want %0d pulses, idle one cycle after last, no halt",
               np, idle_c, last_p, halt_seen, NB);
    end
    if (b2b) begin
      checks++;
      if (last_p - first_p != NB - 1) begin
        failures++;
        $display("FAIL load_back_to_back: pulse span=%0d want %0d", last_p - first_p, NB - 1);
      end
    end
    ref_state = img;
  endtask

  task automatic collect_dump(input int stall_idx, input int stall_len, input bit rnd);
    logic [NC-1:0] exp;
    logic [7:0] hd;
    logic hl;
    logic [AW-1:0] ha;
    int got, wt, first_v;
    bit held, rdy;
    exp = ref_gen(ref_state, 1);
    got = 0; wt = 0; first_v = -1; held = 0;
    hd = '0; hl = 1'b0; ha = '0;
    for (int c = 0; c < 400 && got < NB; c++) begin
      if (rd_valid) begin
        if (first_v < 0) first_v = c;
        if (held) begin
          checks++;
          if ({rd_data, rd_last, ca_addr} !== {hd, hl, ha}) begin
            failures++;
            $display("FAIL dump_hold byte %0d: data=%h last=%b addr=%0d want %h %b %0d",
                     got, rd_data, rd_last, ca_addr, hd, hl, ha);
          end
        end
        rdy = (got == stall_idx && wt < stall_len) ? 1'b0 : (rnd ? 1'($urandom_range(1, 0)) : 1'b1);
        rd_ready = rdy;
        if (rdy) begin
          checks++;
          if ({rd_data, rd_last, ca_addr} !== {exp[got*8 +: 8], (got == NB - 1), AW'(got)}) begin
            failures++;
            $display("FAIL dump_byte %0d: data=%h last=%b addr=%0d want %h %b %0d",
                     got, rd_data, rd_last, ca_addr, exp[got*8 +: 8], (got == NB - 1), got);
          end
          got++; wt = 0; held = 0;
        end else begin
          held = 1; hd = rd_data; hl = rd_last; ha = ca_addr; wt++;
        end
      end else begin
        rd_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b0;
      end
      tick();
    end
    rd_ready = 1'b0;
    checks++;
    if (got != NB || first_v != 2 || busy !== 1'b0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL dump_frame: bytes=%0d first_valid_cycle=%0d busy=%b rd_valid=%b want %0d 2 0 0",
               got, first_v, busy, rd_valid, NB);
    end
  endtask

  task automatic test_dump(input int stall_idx, input int stall_len, input bit rnd);
    issue_cmd(OP_DUMP, '0);
    collect_dump(stall_idx, stall_len, rnd);
  endtask

  task automatic test_run(input int n);
    int hi, end_c;
    bit we_bad;
    hi = 0; end_c = -1; we_bad = 0;
    issue_cmd(OP_RUN, CW'(n));
    for (int c = 0; c < n + 10; c++) begin
      if (ca_halt_n) begin
        hi++;
        if (!ca_we_n) we_bad = 1;
      end else begin
        end_c = c;
        break;
      end
      tick();
    end
    ref_state = ref_gen(ref_state, hi);
    exp_gen = exp_gen + CW'(n);
    checks++;
    if (hi != n || end_c < 0 || we_bad || gen_count !== exp_gen) begin
      failures++;
      $display("FAIL run_%0d: halt_high=%0d end=%0d we_bad=%b gen=%0d want %0d cycles, gen=%0d",
               n, hi, end_c, we_bad, gen_count, n, exp_gen);
    end
`ifdef RULE110_SEQ_AUTO_DUMP_EN
    collect_dump(-1, 0, 0);
`else
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL run_end_idle: busy=%b want 0", busy);
    end
`endif
  endtask

  task automatic test_run_zero();
    bit hs;
    hs = 0;
    issue_cmd(OP_RUN, '0);
    for (int c = 0; c < 4; c++) begin
      if (ca_halt_n) hs = 1;
      if (c == 1) begin
        checks++;
        if ({busy, cmd_ready} !== 2'b01) begin
          failures++;
          $display("FAIL run_zero_idle: busy=%b cmd_ready=%b want 0 1", busy, cmd_ready);
        end
      end
      tick();
    end
    checks++;
    if (hs || gen_count !== exp_gen) begin
      failures++;
      $display("FAIL run_zero: halt_seen=%b gen=%0d want 0 %0d", hs, gen_count, exp_gen);
    end
  endtask

  task automatic test_reserved();
    issue_cmd(OP_RSVD, '0);
    checks++;
    if ({err, busy, cmd_ready} !== 3'b101) begin
      failures++;
      $display("FAIL reserved_op: err=%b busy=%b rdy=%b want 1 0 1", err, busy, cmd_ready);
    end
    issue_cmd(OP_RUN, '0);
    tick(); tick();
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky: err=%b want 1", err);
    end
  endtask

  task automatic test_back_to_back();
    logic [NC-1:0] img;
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < NB; b++) img[b*8 +: 8] = 8'($urandom);
      test_load(img, 1'b0);
      test_run($urandom_range(6, 1));
      test_dump(-1, 0, 1'b1);
    end
  endtask

`ifdef RULE110_SEQ_AUTO_DUMP_EN
  task automatic test_auto_dump();
    logic [NC-1:0] img;
    for (int b = 0; b < NB; b++) img[b*8 +: 8] = 8'($urandom);
    test_load(img, 1'b1);
    test_run(1);
  endtask
`endif

  task automatic test_reset_mid_run();
    int hi;
    hi = 0;
    issue_cmd(OP_RUN, CW'(10));
    for (int c = 0; c < 20 && hi < 2; c++) begin
      if (ca_halt_n) hi++;
      if (hi < 2) tick();
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({ca_halt_n, ca_we_n, busy, cmd_ready, gen_count, err} !== {1'b0, 1'b1, 1'b0, 1'b0, CW'(0), 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_run: halt_n=%b we_n=%b busy=%b rdy=%b gen=%0d err=%b want 0 1 0 0 0 0",
               ca_halt_n, ca_we_n, busy, cmd_ready, gen_count, err);
    end
    reset = 1'b0;
    exp_gen = '0;
    ref_state = ref_gen(ref_state, hi);
    tick();
    checks++;
    if ({cmd_ready, busy, ca_halt_n} !== 3'b100) begin
      failures++;
      $display("FAIL reset_mid_run_idle: rdy=%b busy=%b halt_n=%b want 1 0 0", cmd_ready, busy, ca_halt_n);
    end
    test_dump(-1, 0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = '0;
    wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;
    ref_state = '0; exp_gen = '0;
    test_reset();
    test_load({8'h01, 8'hD7, 8'hE6, 8'h07}, 1'b1);
    test_run(3);
    test_dump(-1, 0, 1'b0);
    test_dump(1, 5, 1'b0);
    test_run_zero();
    test_reserved();
    test_back_to_back();
`ifdef RULE110_SEQ_AUTO_DUMP_EN
    test_auto_dump();
`endif
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rule110_sequencer.md
Name: rule110_sequencer

Overview:
- Host-side controller for the Rule 110 cell array. Drives the array's control pins: write_enable_n, halt_n, block address and data_in. Reads the array's data_out.
- Accepts LOAD, RUN and DUMP commands over a valid/ready interface.
- LOAD streams initial cell bytes into the array. RUN advances exactly N generations. DUMP streams every cell block back out.
- Sits between a host bus or UART bridge and the cell array.

Parameters:
- NUM_BLOCKS, 30, number of 8-cell blocks in the array (240 cells). Legal range 1..62.
- ADDR_W, 6, width of the block address pins.
- CNT_W, 16, width of the RUN generation count and of gen_count.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command valid
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  00 LOAD, 01 RUN, 10 DUMP, 11 reserved
- cmd_count  in  CNT_W  generations for RUN; ignored otherwise
- wr_valid  in  1  LOAD byte valid
- wr_ready  out  1  LOAD byte accepted
- wr_data  in  8  LOAD byte, block 0 first
- rd_valid  out  1  DUMP byte valid
- rd_ready  in  1  DUMP byte consumed
- rd_data  out  8  DUMP byte
- rd_last  out  1  marks the byte of block NUM_BLOCKS-1
- ca_we_n  out  1  to array write_enable_n
- ca_halt_n  out  1  to array halt_n
- ca_addr  out  ADDR_W  to array block address
- ca_data_in  out  8  to array data_in
- ca_data_out  in  8  from array data_out (combinational T+1 view of the addressed block)
- busy  out  1  high when not in IDLE
- gen_count  out  CNT_W  generations executed since reset; wraps
- err  out  1  sticky; set on the reserved opcode

Behaviour:
- All outputs are registered.
- Reset values:
  - cmd_ready=0 in the reset cycle, then 1.
  - ca_we_n=1, ca_halt_n=0, ca_addr=0, ca_data_in=0.
  - wr_ready=0, rd_valid=0, rd_last=0, busy=0, gen_count=0, err=0.
- States: IDLE, LOAD, RUN, DUMP_ADDR, DUMP_CAP, DUMP_OUT.
- IDLE:
  - ca_halt_n=0, ca_we_n=1, cmd_ready=1.
  - cmd_valid&&cmd_ready accepts a command. The next state follows the op.
  - op 11: set err, stay in IDLE.
- LOAD:
  - Block index blk runs 0..NUM_BLOCKS-1. wr_ready=1.
  - On each wr_valid&&wr_ready: next cycle drives ca_addr=blk, ca_data_in=wr_data, ca_we_n=0 for exactly one cycle, and blk increments.
  - ca_we_n is 1 whenever no byte was accepted in the previous cycle.
  - Back-to-back bytes are allowed at one per cycle.
  - After the pulse for block NUM_BLOCKS-1, return to IDLE with ca_we_n=1.
  - ca_halt_n stays 0 throughout LOAD.
- RUN:
  - cmd_count=0: return to IDLE the next cycle. No generation is executed.
  - Otherwise ca_halt_n=1 for exactly cmd_count consecutive cycles, with ca_we_n=1.
  - gen_count increments once per such cycle.
  - Then ca_halt_n=0 and return to IDLE.
- DUMP:
  - DUMP_ADDR: drive ca_addr=blk (halted).
  - DUMP_CAP: register ca_data_out into rd_data. rd_valid=1; rd_last=(blk==NUM_BLOCKS-1).
  - DUMP_OUT: hold rd_data/rd_valid/rd_last stable until rd_ready. Then clear rd_valid. If blk was last, go to IDLE; else increment blk and go to DUMP_ADDR.
  - Per-byte latency: 2 cycles from address drive to rd_valid.
  - The data dumped is the T+1 view of each block. This is the array's native read semantics; the controller does not correct it.
- Address rules:
  - ca_addr never exceeds NUM_BLOCKS-1, so the all-ones address (aliased to 0 by the array) is never driven.
  - blk resets to 0 on entry to LOAD and DUMP.
- Reset mid-operation:
  - Aborts immediately to IDLE. ca_halt_n=0 and ca_we_n=1 in the cycle after reset is sampled.
  - A partial LOAD or DUMP is discarded.
- cmd_valid outside IDLE is ignored (not queued).

Optional Feature:
- RULE110_SEQ_AUTO_DUMP_EN defined:
  - A nonzero RUN ends by entering DUMP_ADDR with blk=0 instead of IDLE. One complete dump follows automatically.
  - RUN with cmd_count=0 still returns to IDLE.
- Undefined: RUN always returns to IDLE.

Decomposition:
- Package rule110_pkg holds:
  - enum seq_state_t (the six states);
  - localparams OP_LOAD=2'b00, OP_RUN=2'b01, OP_DUMP=2'b10, OP_RSVD=2'b11;
  - CELLS_PER_BLOCK=8.
- No sub-module.
- For benches, a behavioural model of the cell array (rule110_array_model) lives in tb only.

Test Plan:
- Reset, then idle 5 cycles: ca_halt_n=0, ca_we_n=1, cmd_ready=1, gen_count=0, err=0.
- LOAD with NUM_BLOCKS=4, bytes 07,E6,D7,01 back-to-back: exactly four 1-cycle ca_we_n pulses at addr 0,1,2,3 with matching ca_data_in; busy drops the cycle after the last pulse.
- LOAD then RUN cmd_count=3:
  - ca_halt_n high for exactly 3 cycles; gen_count=3.
  - A following DUMP matches the model's generation-4 (T+1) view.
  - rd_last only on the 4th byte.
- DUMP with rd_ready low for 5 cycles on byte 1: rd_data and rd_valid held stable; no address advance; all bytes delivered in order.
- RUN cmd_count=0: returns to IDLE in 1 cycle, ca_halt_n never high. Opcode 11: err=1 and stays 1.
- Reset asserted mid-RUN after 2 of 10 generations: next cycle ca_halt_n=0 and IDLE. With RULE110_SEQ_AUTO_DUMP_EN, RUN 1 is followed by NUM_BLOCKS rd beats without a DUMP command.
